// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the five-stage pipeline. Owns the program
// counter, addresses a synchronous instruction ROM and presents each fetched
// word, paired with its incremented PC, to the F/D pipeline latch.
//
// Handshake toward F/D: out_valid is "valid"; the inverse of stall is
// "ready". An instruction is transferred on a rising edge only when
// out_valid=1 and stall=0. While out_valid=1 and stall=1, out_ir and out_pc
// stay stable until they are transferred or a redirect discards them.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous, active-low; clears all state immediately
//   stall        hazard unit hold request (F/D latch enable is ~stall)
//   redirect     taken branch/jump from execute; overrides stall
//   redirect_pc  target word address, valid while redirect=1
//   imem_addr    word address to the ROM (fetch_pc truncated)
//   imem_data    ROM data for the address sampled at the previous edge
//   out_pc       address of out_ir plus 1
//   out_ir       instruction word, NOP_WORD when out_valid=0
//   out_valid    out_ir/out_pc carry a real instruction
//   fsm_state    current FSM state (FILL=0, RUN=1, HOLD=2) for observation
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          IMEM_ADDR_WIDTH = 12,
  parameter logic [31:0] NOP_WORD        = 32'h0000_0000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]                imem_data,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_ir,
  output logic                       out_valid,
  output logic [1:0]                 fsm_state
);

  localparam logic [1:0] FILL = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [31:0] fetch_pc;  // address presented to the ROM this cycle
  logic [31:0] req_pc;    // address whose data is on imem_data now
  logic [31:0] hold_ir;
  logic [31:0] hold_pc;
  logic [1:0]  state;

  // ROM address follows fetch_pc directly, so during reset it already
  // shows RESET_PC and it wraps on its own narrower width.
  assign imem_addr = fetch_pc[IMEM_ADDR_WIDTH-1:0];
  assign fsm_state = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      hold_ir  <= 32'h0000_0000;
      hold_pc  <= 32'h0000_0000;
      state    <= FILL;
    end else if (redirect) begin
      // Wrong-path data (on imem_data or in the hold buffer) is simply
      // abandoned; FILL waits one cycle for the target's ROM read.
      fetch_pc <= redirect_pc;
      state    <= FILL;
    end else begin
      case (state)
        FILL: begin
          // Nothing valid to buffer yet, so stall has no effect here.
          req_pc   <= fetch_pc;
          fetch_pc <= fetch_pc + 32'd1;
          state    <= RUN;
        end
        RUN: begin
          if (stall) begin
            // Capture the word now, because the ROM output will move on
            // to fetch_pc at this edge. fetch_pc is kept so that the read
            // is reissued when the stall releases.
            hold_ir <= imem_data;
            hold_pc <= req_pc;
            state   <= HOLD;
          end else begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd1;
          end
        end
        HOLD: begin
          if (!stall) begin
            // The held word is transferred this edge; the ROM reads the
            // next sequential address at the same edge.
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd1;
            state    <= RUN;
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_ir    = NOP_WORD;
    out_pc    = 32'h0000_0000;
    if (!redirect) begin
      case (state)
        RUN: begin
          out_valid = 1'b1;
          out_ir    = imem_data;
          out_pc    = req_pc + 32'd1;
        end
        HOLD: begin
          out_valid = 1'b1;
          out_ir    = hold_ir;
          out_pc    = hold_pc + 32'd1;
        end
        default: begin
          out_valid = 1'b0;
          out_ir    = NOP_WORD;
          out_pc    = 32'h0000_0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Two instances: dut_a starts at address 0 and is driven through streaming,
// stall, redirect and reset scenarios; dut_b starts at 32'hFFFF_FFFF and
// checks PC and ROM-address wrap. Each has its own behavioural ROM holding
// 32'hA000_0000 + word address.
//
// Instructions transferred by dut_a (out_valid=1, stall=0) are compared in
// order against an expected queue filled whenever the bench starts a new
// sequential stream.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // ---------------- dut_a signals ----------------
  logic        stall       = 1'b0;
  logic        redirect    = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [11:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] out_pc;
  logic [31:0] out_ir;
  logic        out_valid;
  logic [1:0]  fsm_state;

  // ---------------- dut_b signals ----------------
  logic        stall_b       = 1'b0;
  logic        redirect_b    = 1'b0;
  logic [31:0] redirect_pc_b = 32'h0;
  logic [11:0] imem_addr_b;
  logic [31:0] imem_data_b;
  logic [31:0] out_pc_b;
  logic [31:0] out_ir_b;
  logic        out_valid_b;
  logic [1:0]  fsm_state_b;

  fetch_stage #(
    .RESET_PC(32'h0000_0000), .IMEM_ADDR_WIDTH(12), .NOP_WORD(32'h0000_0000)
  ) dut_a (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_data(imem_data),
    .out_pc(out_pc), .out_ir(out_ir), .out_valid(out_valid),
    .fsm_state(fsm_state)
  );

  fetch_stage #(
    .RESET_PC(32'hFFFF_FFFF), .IMEM_ADDR_WIDTH(12), .NOP_WORD(32'h0000_0000)
  ) dut_b (
    .clock(clock), .reset(reset), .stall(stall_b), .redirect(redirect_b),
    .redirect_pc(redirect_pc_b), .imem_addr(imem_addr_b),
    .imem_data(imem_data_b), .out_pc(out_pc_b), .out_ir(out_ir_b),
    .out_valid(out_valid_b), .fsm_state(fsm_state_b)
  );

  // Synchronous ROMs: word at address a is 32'hA000_0000 + a.
  always @(posedge clock) imem_data   <= 32'hA000_0000 + {20'h0, imem_addr};
  always @(posedge clock) imem_data_b <= 32'hA000_0000 + {20'h0, imem_addr_b};

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];   // {expected out_pc, expected out_ir}
  int          n_vec  = 0;
  int          n_miss = 0;
  logic        mon_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_stream(input logic [31:0] start, input int count);
    for (int i = 0; i < count; i++) begin
      logic [31:0] a;
      a = start + i;
      exp_q.push_back({a + 32'd1, 32'hA000_0000 + {20'h0, a[11:0]}});
    end
  endtask

  // Compares the current cycle's transfer, if any, against the queue.
  task automatic monitor_sample();
    logic [63:0] e;
    if (mon_en && out_valid && !stall) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 64'd0, 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", {32'h0, out_pc}, {32'h0, e[63:32]});
        check("sb_ir", {32'h0, out_ir}, {32'h0, e[31:0]});
      end
    end
  endtask

  // Finish the current cycle, then apply the next cycle's inputs and settle.
  task automatic next(input logic s, input logic r, input logic [31:0] rp);
    monitor_sample();
    @(negedge clock);
    stall       = s;
    redirect    = r;
    redirect_pc = rp;
    #1;
  endtask

  task automatic check_out(input string tag, input logic v,
                           input logic [31:0] ir, input logic [31:0] pc);
    check({tag, "_valid"}, {63'h0, out_valid}, {63'h0, v});
    check({tag, "_ir"}, {32'h0, out_ir}, {32'h0, ir});
    check({tag, "_pc"}, {32'h0, out_pc}, {32'h0, pc});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held: both instances show reset outputs.
    repeat (2) @(negedge clock);
    #1;
    check_out("rst", 1'b0, 32'h0, 32'h0);
    check("rst_addr", {52'h0, imem_addr}, 64'h0);
    check("rst_state", {62'h0, fsm_state}, {62'h0, S_FILL});
    check("rst_b_addr", {52'h0, imem_addr_b}, 64'hFFF);
    check("rst_b_valid", {63'h0, out_valid_b}, 64'h0);

    // Release; cycle 0 is a bubble.
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("c0_valid", {63'h0, out_valid}, 64'h0);
    check("c0_b_addr", {52'h0, imem_addr_b}, 64'hFFF);
    push_stream(32'h0, 6);
    mon_en = 1'b1;

    next(1'b0, 1'b0, 32'h0);  // cycle 1
    check_out("c1", 1'b1, 32'hA000_0000, 32'h1);
    check("wrap_b_pc", {32'h0, out_pc_b}, 64'h0);
    check("wrap_b_ir", {32'h0, out_ir_b}, 64'hA000_0FFF);
    check("wrap_b_valid", {63'h0, out_valid_b}, 64'h1);
    check("wrap_b_addr", {52'h0, imem_addr_b}, 64'h000);
    next(1'b0, 1'b0, 32'h0);  // cycle 2
    check_out("c2", 1'b1, 32'hA000_0001, 32'h2);
    check("wrap_b_pc2", {32'h0, out_pc_b}, 64'h1);
    check("wrap_b_ir2", {32'h0, out_ir_b}, 64'hA000_0000);
    next(1'b0, 1'b0, 32'h0);  // cycle 3
    next(1'b0, 1'b0, 32'h0);  // cycle 4

    // Stall 3 cycles on A000_0004: visible for 4 cycles, then 5 follows.
    for (int i = 0; i < 3; i++) begin
      next(1'b1, 1'b0, 32'h0);
      check_out("stall_hold", 1'b1, 32'hA000_0004, 32'h5);
    end
    check("stall_state", {62'h0, fsm_state}, {62'h0, S_HOLD});
    next(1'b0, 1'b0, 32'h0);
    check_out("stall_release", 1'b1, 32'hA000_0004, 32'h5);
    next(1'b0, 1'b0, 32'h0);
    check_out("after_stall", 1'b1, 32'hA000_0005, 32'h6);

    // Redirect to 0x40 while A000_0006 is presented.
    next(1'b0, 1'b1, 32'h40);
    check_out("redir", 1'b0, 32'h0, 32'h0);
    check("redir_consumed", {32'h0, 32'(exp_q.size())}, 64'h0);
    exp_q.delete();
    push_stream(32'h40, 64);
    next(1'b0, 1'b0, 32'h0);
    check_out("redir_fill", 1'b0, 32'h0, 32'h0);
    check("redir_fill_state", {62'h0, fsm_state}, {62'h0, S_FILL});
    next(1'b0, 1'b0, 32'h0);
    check_out("redir_tgt", 1'b1, 32'hA000_0040, 32'h41);

    // Random stall pattern: every transfer must be the next address.
    for (int i = 0; i < 40; i++) begin
      next(1'($urandom_range(0, 1)), 1'b0, 32'h0);
    end

    // Enter HOLD, then redirect and stall together.
    next(1'b1, 1'b0, 32'h0);
    next(1'b1, 1'b0, 32'h0);
    check("pre_rs_state", {62'h0, fsm_state}, {62'h0, S_HOLD});
    next(1'b1, 1'b1, 32'h100);
    check_out("rs_redir", 1'b0, 32'h0, 32'h0);
    exp_q.delete();
    push_stream(32'h100, 5);
    next(1'b1, 1'b0, 32'h0);
    check("rs_fill_state", {62'h0, fsm_state}, {62'h0, S_FILL});
    check("rs_fill_valid", {63'h0, out_valid}, 64'h0);
    next(1'b1, 1'b0, 32'h0);
    check_out("rs_tgt", 1'b1, 32'hA000_0100, 32'h101);
    next(1'b0, 1'b0, 32'h0);
    check_out("rs_tgt_rel", 1'b1, 32'hA000_0100, 32'h101);
    next(1'b0, 1'b0, 32'h0);
    check_out("rs_next", 1'b1, 32'hA000_0101, 32'h102);

    // Reach HOLD with hold_ir=A000_0009, then assert reset mid-cycle.
    next(1'b0, 1'b1, 32'h9);
    exp_q.delete();
    next(1'b0, 1'b0, 32'h0);
    next(1'b1, 1'b0, 32'h0);
    next(1'b1, 1'b0, 32'h0);
    check("hold9_state", {62'h0, fsm_state}, {62'h0, S_HOLD});
    check_out("hold9", 1'b1, 32'hA000_0009, 32'hA);
    #1;
    reset = 1'b0;
    #1;  // still before the next rising edge
    check_out("async_rst", 1'b0, 32'h0, 32'h0);
    check("async_rst_state", {62'h0, fsm_state}, {62'h0, S_FILL});
    check("async_rst_addr", {52'h0, imem_addr}, 64'h0);
    mon_en = 1'b0;
    stall  = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst2_c0_valid", {63'h0, out_valid}, 64'h0);
    push_stream(32'h0, 4);
    mon_en = 1'b1;
    next(1'b0, 1'b0, 32'h0);
    check_out("rst2_c1", 1'b1, 32'hA000_0000, 32'h1);
    for (int i = 0; i < 4; i++) next(1'b0, 1'b0, 32'h0);
    check("rst2_consumed", {32'h0, 32'(exp_q.size())}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Safety bound on total runtime.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage pipeline. It owns the program counter, drives the synchronous instruction memory and presents the fetched instruction word to the F/D pipeline latch. The instruction is presented with its incremented PC (PC+1). It honours hazard-unit stalls by buffering the returned instruction, and branch/jump redirects from execute by discarding wrong-path fetches.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- IMEM_ADDR_WIDTH, 12, instruction-memory word-address width
- NOP_WORD, 32'h0000_0000, word driven on out_ir when out_valid=0

Ports:
- clock  in  1  rising-edge clock, the only clock
- reset  in  1  asynchronous, active-low; low clears all state immediately
- stall  in  1  hazard unit: hold the current output; the F/D latch enable is its inverse
- redirect  in  1  taken branch/jump from execute
- redirect_pc  in  32  target word address, valid while redirect=1
- imem_addr  out  IMEM_ADDR_WIDTH  fetch_pc[IMEM_ADDR_WIDTH-1:0]
- imem_data  in  32  synchronous ROM data for the address sampled at the previous rising edge
- out_pc  out  32  address of out_ir plus 1, feeds latch in_pc
- out_ir  out  32  instruction word, feeds latch in_ir
- out_valid  out  1  out_ir/out_pc hold a real instruction

## Operation
- State: fetch_pc[31:0], req_pc[31:0] (address whose data is on imem_data), hold_ir[31:0], hold_pc[31:0], FSM {FILL, RUN, HOLD}.
- Reset (reset=0, async): fetch_pc=RESET_PC, req_pc=RESET_PC, hold_ir=0, hold_pc=0, state=FILL.
  - Outputs during reset: out_valid=0, out_ir=NOP_WORD, out_pc=0, imem_addr=RESET_PC[IMEM_ADDR_WIDTH-1:0].
- Output mux is combinational from state and inputs:
  - FILL: out_valid=0, out_ir=NOP_WORD, out_pc=0.
  - RUN: out_valid=1, out_ir=imem_data, out_pc=req_pc+1.
  - HOLD: out_valid=1, out_ir=hold_ir, out_pc=hold_pc+1.
  - redirect=1 in any state overrides the above: out_valid=0, out_ir=NOP_WORD, out_pc=0.
- Transitions. Priority is reset > redirect > stall.
  - Any state, redirect=1: fetch_pc<=redirect_pc, state<=FILL. The hold buffer is discarded.
  - FILL, no redirect: req_pc<=fetch_pc, fetch_pc<=fetch_pc+1, state<=RUN. Stall is ignored in FILL because there is nothing to buffer.
  - RUN, stall=0: req_pc<=fetch_pc, fetch_pc<=fetch_pc+1, stay in RUN.
  - RUN, stall=1: hold_ir<=imem_data, hold_pc<=req_pc, state<=HOLD. fetch_pc is unchanged.
  - HOLD, stall=1: all registers unchanged. imem_data is ignored.
  - HOLD, stall=0: req_pc<=fetch_pc, fetch_pc<=fetch_pc+1, state<=RUN. The next output is the instruction at the old fetch_pc.
- Arithmetic: every +1 is 32-bit modulo 2^32. imem_addr is fetch_pc truncated to IMEM_ADDR_WIDTH bits, so it wraps independently of fetch_pc.
- Sequence guarantee: with no redirect, the valid outputs accepted (cycles with out_valid=1 and stall=0) are consecutive addresses. No address is skipped or duplicated across any stall pattern.

## Timing
- Fetch latency: an address presented at edge N appears on out_ir after edge N+1.
- After reset release: the first clock edge enters RUN. Instruction RESET_PC is valid in the following cycle.
- Redirect penalty: the redirect cycle plus one FILL cycle are bubbles. The target instruction is valid in the second cycle after the redirect edge.
- A stall adds no bubbles. The output released from HOLD is followed in the next cycle by the next sequential instruction.
- Reset asserted in any state forces the reset outputs within the same cycle, asynchronously.

## Test plan
- Reset and stream, imem[i]=32'hA000_0000+i, RESET_PC=0: cycle 0 after release out_valid=0. Cycle 1 gives out_ir=A000_0000, out_pc=1. Cycle 2 gives A000_0001, out_pc=2, and so on.
- Stall for 3 cycles while out_ir=A000_0004: out_ir=A000_0004 and out_pc=5 persist for 4 cycles. The next cycle gives A000_0005 and out_pc=6, with no skip.
- Redirect to 32'h40 while out_ir=A000_0006: that cycle gives out_valid=0 and NOP. The next cycle has out_valid=0. Then out_ir=A000_0040, out_pc=32'h41.
- Redirect and stall together while in HOLD: redirect wins. hold_ir is discarded, the state goes to FILL, and the target is output two cycles later.
- Drive reset low mid-HOLD with hold_ir=A000_0009: out_valid=0 and out_pc=0 immediately, without waiting for a clock edge. After release, fetch restarts at RESET_PC.
- Wrap, RESET_PC=32'hFFFF_FFFF: first valid output has out_pc=0 and imem_addr=12'hFFF. The next fetch uses imem_addr=12'h000 and gives out_pc=1.
